uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_tx.sv | 114 +++++++++++
 tb/tb_uart_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity-mode constants, FSM state encoding and parity helper shared by the uart transmitter and receiver
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // Payload is zero-extended to 9 bits; extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (mode == PARITY_EVEN) ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: single-cycle bit-end tick every P_DIV clocks, restarted by i_clr
//   i_clk  : system clock, rising edge
//   i_rst  : asynchronous active-high reset
//   i_clr  : hold the counter at zero (restart the bit period)
//   o_tick : high during the last clock of each bit period
module uart_baud_gen #(
    parameter int P_DIV = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = $clog2(P_DIV);

    logic [CW-1:0] cnt;

    assign o_tick = (cnt == CW'(P_DIV - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cnt <= '0;
        else
            cnt <= (i_clr || o_tick) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with configurable data width, parity mode and stop bits
//   i_clk      : system clock, rising edge
//   i_rst      : asynchronous active-high reset (line forced high)
//   i_tx_data  : payload, latched on the accept edge
//   i_tx_valid : payload offered; accepted when o_tx_ready is high
//   o_tx_ready : idle and able to accept a payload
//   o_uart_tx  : registered serial line, idle high
//   o_tx_busy  : frame in progress (inverse of o_tx_ready)
module uart_tx
    import uart_pkg::*;
#(
    parameter int P_SYSTEM_CLK      = 50_000_000,
    parameter int P_UART_BURD_RATE  = 9600,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_UART_CHECK_ON   = 1,
    parameter int P_UART_STOP_WIDTH = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [P_UART_DATA_WIDTH-1:0] i_tx_data,
    input  logic                         i_tx_valid,
    output logic                         o_tx_ready,
    output logic                         o_uart_tx,
    output logic                         o_tx_busy
);

    localparam int D = P_SYSTEM_CLK / P_UART_BURD_RATE;

    if (D < 2) begin : g_div_err
        $error("uart_tx: clock/baud divisor must be at least 2");
    end
    if (P_UART_CHECK_ON < 0 || P_UART_CHECK_ON > 2) begin : g_par_err
        $error("uart_tx: parity mode must be 0, 1 or 2");
    end
    if (P_UART_DATA_WIDTH < 5 || P_UART_DATA_WIDTH > 9) begin : g_width_err
        $error("uart_tx: data width must be 5..9");
    end
    if (P_UART_STOP_WIDTH < 1 || P_UART_STOP_WIDTH > 2) begin : g_stop_err
        $error("uart_tx: stop width must be 1 or 2");
    end

    uart_state_t                  state;
    logic [P_UART_DATA_WIDTH-1:0] shreg;
    logic [3:0]                   bit_cnt;
    logic                         par;
    logic                         tick;
    logic                         accept;

    assign accept    = i_tx_valid && o_tx_ready;
    assign o_tx_busy = ~o_tx_ready;

    // Holding the counter clear while idle makes it restart at 0 on the accept edge.
    uart_baud_gen #(.P_DIV(D)) u_baud (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (state == ST_IDLE),
        .o_tick (tick)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            o_tx_ready <= 1'b0;
            o_uart_tx  <= 1'b1;
            shreg      <= '0;
            bit_cnt    <= '0;
            par        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_tx_ready <= ~accept;
                    o_uart_tx  <= ~accept;
                    if (accept) begin
                        state <= ST_START;
                        shreg <= i_tx_data;
                        par   <= parity_bit(9'(i_tx_data), P_UART_CHECK_ON);
                    end
                end
                ST_START: if (tick) begin
                    state     <= ST_DATA;
                    o_uart_tx <= shreg[0];
                    shreg     <= shreg >> 1;
                    bit_cnt   <= '0;
                end
                ST_DATA: if (tick) begin
                    if (bit_cnt == 4'(P_UART_DATA_WIDTH - 1)) begin
                        state     <= (P_UART_CHECK_ON != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        o_uart_tx <= (P_UART_CHECK_ON != PARITY_NONE) ? par : 1'b1;
                        bit_cnt   <= '0;
                    end else begin
                        o_uart_tx <= shreg[0];
                        shreg     <= shreg >> 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                end
                ST_PARITY: if (tick) begin
                    state     <= ST_STOP;
                    o_uart_tx <= 1'b1;
                    bit_cnt   <= '0;
                end
                ST_STOP: if (tick) begin
                    if (bit_cnt == 4'(P_UART_STOP_WIDTH - 1)) begin
                        state      <= ST_IDLE;
                        o_tx_ready <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx across odd/even/none parity and 1/2 stop-bit configurations
module tb_uart_tx;

    localparam int D = 16;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data   [4];
    logic       tx_valid  [4];
    logic       tx_ready  [4];
    logic       uart_line [4];
    logic       tx_busy   [4];

    int mode_c [4] = '{1, 2, 0, 1};
    int stop_c [4] = '{1, 1, 1, 2};
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx #(.P_SYSTEM_CLK(16), .P_UART_BURD_RATE(1), .P_UART_DATA_WIDTH(8),
              .P_UART_CHECK_ON(1), .P_UART_STOP_WIDTH(1)) u_odd (
        .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data[0]), .i_tx_valid(tx_valid[0]),
        .o_tx_ready(tx_ready[0]), .o_uart_tx(uart_line[0]), .o_tx_busy(tx_busy[0]));

    uart_tx #(.P_SYSTEM_CLK(16), .P_UART_BURD_RATE(1), .P_UART_DATA_WIDTH(8),
              .P_UART_CHECK_ON(2), .P_UART_STOP_WIDTH(1)) u_even (
        .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data[1]), .i_tx_valid(tx_valid[1]),
        .o_tx_ready(tx_ready[1]), .o_uart_tx(uart_line[1]), .o_tx_busy(tx_busy[1]));

    uart_tx #(.P_SYSTEM_CLK(16), .P_UART_BURD_RATE(1), .P_UART_DATA_WIDTH(8),
              .P_UART_CHECK_ON(0), .P_UART_STOP_WIDTH(1)) u_none (
        .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data[2]), .i_tx_valid(tx_valid[2]),
        .o_tx_ready(tx_ready[2]), .o_uart_tx(uart_line[2]), .o_tx_busy(tx_busy[2]));

    uart_tx #(.P_SYSTEM_CLK(16), .P_UART_BURD_RATE(1), .P_UART_DATA_WIDTH(8),
              .P_UART_CHECK_ON(1), .P_UART_STOP_WIDTH(2)) u_stop2 (
        .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data[3]), .i_tx_valid(tx_valid[3]),
        .o_tx_ready(tx_ready[3]), .o_uart_tx(uart_line[3]), .o_tx_busy(tx_busy[3]));

    function automatic int frame_bits(input int k);
        return 1 + W + ((mode_c[k] != 0) ? 1 : 0) + stop_c[k];
    endfunction

    // Expected line, one entry per clock after the accept edge, ending with one idle-high cycle.
    function automatic logic [255:0] model(input int k, input logic [7:0] d);
        bit          q[$];
        logic [255:0] v = '0;
        int          ones = $countones(d);
        q.push_back(1'b0);
        for (int i = 0; i < W; i++) q.push_back(d[i]);
        if (mode_c[k] == 1) q.push_back(ones % 2 == 0);
        if (mode_c[k] == 2) q.push_back(ones % 2 == 1);
        for (int s = 0; s < stop_c[k]; s++) q.push_back(1'b1);
        for (int b = 0; b < q.size(); b++)
            for (int c = 0; c < D; c++) v[b*D + c] = q[b];
        v[q.size()*D] = 1'b1;
        return v;
    endfunction

    // Offers d on instance k (caller is at a negedge), then records one whole frame.
    // raise_at: cycle index at which valid is re-asserted with next_d (-1 never, 0 held through).
    task automatic run_frame(input int k, input logic [7:0] d, input int raise_at,
                             input logic [7:0] next_d, input string name, output int waited);
        int           nd = frame_bits(k) * D;
        logic [255:0] got = '0;
        logic [255:0] exp;
        int           lat = -1;
        int           busy_bad = 0;
        exp = model(k, d);
        tx_valid[k] = 1'b1;
        tx_data[k]  = d;
        waited = 0;
        while (!tx_ready[k] && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (tx_ready[k] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s accept_timeout: ready=%b required 1", name, tx_ready[k]);
            tx_valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        for (int i = 0; i <= nd; i++) begin
            @(negedge clk);
            if (i == 0) begin
                tx_valid[k] = (raise_at == 0);
                tx_data[k]  = (raise_at == 0) ? next_d : 8'($urandom);
            end else if (i == raise_at) begin
                tx_valid[k] = 1'b1;
                tx_data[k]  = next_d;
            end
            got[i] = uart_line[k];
            if (tx_ready[k] === 1'b1 && lat < 0) lat = i;
            if (tx_busy[k] !== ~tx_ready[k]) busy_bad++;
        end
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s line: got %h required %h", name, got, exp);
        end
        n_cmp++;
        if (lat + 1 !== nd + 1) begin
            n_bad++;
            $display("FAIL %s accept_to_ready: got %0d cycles required %0d", name, lat + 1, nd + 1);
        end
        n_cmp++;
        if (busy_bad !== 0) begin
            n_bad++;
            $display("FAIL %s busy_vs_ready: got %0d bad cycles required 0", name, busy_bad);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({uart_line[k], tx_ready[k], tx_busy[k]} !== 3'b101) begin
                n_bad++;
                $display("FAIL reset_state[%0d]: line/ready/busy=%b required 101", k,
                         {uart_line[k], tx_ready[k], tx_busy[k]});
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (tx_ready[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL ready_after_reset[%0d]: got %b required 1", k, tx_ready[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_odd_0x55;
        int w;
        run_frame(0, 8'h55, -1, 8'h00, "odd_0x55", w);
    endtask

    task automatic test_parity_modes;
        int w;
        run_frame(1, 8'h07, -1, 8'h00, "even_0x07", w);
        run_frame(2, 8'h07, -1, 8'h00, "none_0x07", w);
    endtask

    task automatic test_two_stop;
        int w;
        run_frame(3, 8'hFF, -1, 8'h00, "stop2_0xFF", w);
    endtask

    task automatic test_back_to_back;
        int w;
        run_frame(0, 8'hA5, 0, 8'h3C, "b2b_first", w);
        run_frame(0, 8'h3C, -1, 8'h00, "b2b_second", w);
        n_cmp++;
        if (w !== 0) begin
            n_bad++;
            $display("FAIL b2b_gap: waited %0d extra cycles required 0", w);
        end
    endtask

    task automatic test_valid_while_busy;
        int         w;
        logic [7:0] d1 = 8'($urandom);
        logic [7:0] d2 = 8'($urandom);
        int         at = $urandom_range(1, frame_bits(1) * D - 1);
        run_frame(1, d1, at, d2, "busy_first", w);
        run_frame(1, d2, -1, 8'h00, "busy_second", w);
        n_cmp++;
        if (w !== 0) begin
            n_bad++;
            $display("FAIL busy_accept_wait: waited %0d cycles required 0", w);
        end
    endtask

    task automatic test_random;
        int w;
        for (int k = 0; k < 4; k++)
            for (int n = 0; n < 3; n++)
                run_frame(k, 8'($urandom), -1, 8'h00, $sformatf("random_%0d_%0d", k, n), w);
    endtask

    task automatic test_reset_mid_frame;
        int         w;
        logic [7:0] d = 8'($urandom);
        tx_valid[0] = 1'b1;
        tx_data[0]  = d;
        w = 0;
        while (!tx_ready[0] && w < 2000) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            tx_valid[0] = 1'b0;
        end
        n_cmp++;
        if (uart_line[0] !== d[3]) begin
            n_bad++;
            $display("FAIL mid_bit3: line=%b required %b", uart_line[0], d[3]);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({uart_line[0], tx_ready[0], tx_busy[0]} !== 3'b101) begin
            n_bad++;
            $display("FAIL async_reset: line/ready/busy=%b required 101",
                     {uart_line[0], tx_ready[0], tx_busy[0]});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({uart_line[0], tx_ready[0]} !== 2'b11) begin
            n_bad++;
            $display("FAIL release_ready: line/ready=%b required 11", {uart_line[0], tx_ready[0]});
        end
        @(negedge clk);
        run_frame(0, 8'($urandom), -1, 8'h00, "after_reset", w);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            tx_valid[k] = 1'b0;
            tx_data[k]  = 8'h00;
        end
        test_reset;
        test_odd_0x55;
        test_parity_modes;
        test_two_stop;
        test_back_to_back;
        test_valid_while_busy;
        test_random;
        test_reset_mid_frame;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
